// File: rtl/dbus_resp_pkg.sv
// Shared types and helpers for the dBus memory responder.
//   size_e      : dBus access size encoding (byte / half / word, 3 is illegal)
//   rsp_entry_t : one read response (aligned word plus error flag)
//   byte_mask() : byte-lane write enables for a size and low address bits
//   is_misaligned() : alignment rule for half and word accesses
package dbus_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } rsp_entry_t;

    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size_e'(size))
            SZ_BYTE: byte_mask = 4'b0001 << lane;
            SZ_HALF: byte_mask = 4'b0011 << lane;
            SZ_WORD: byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size_e'(size))
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_rsp_fifo.sv
// Synchronous FIFO of read responses.
//   clock, reset_n : clock, asynchronous active-low reset (pointers/fill only)
//   push, push_entry : write one entry (caller guarantees not full)
//   pop            : retire the head entry (caller guarantees not empty)
//   head           : current head entry
//   empty, count   : occupancy status
module dbus_rsp_fifo
    import dbus_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  rsp_entry_t                   push_entry,
    input  logic                         pop,
    output rsp_entry_t                   head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rsp_entry_t       store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) store[wr_ptr] <= push_entry;
    end

    assign head  = store[rd_ptr];
    assign empty = (fill == '0);
    assign count = fill;

endmodule

// File: rtl/dbus_mem_responder.sv
// Memory-side responder for the VexRiscv simple dBus.
// Writes land in RAM at acceptance and produce no response; reads are answered
// in order with a one-cycle dBus_rsp_ready pulse RSP_LATENCY+1 edges after acceptance.
//   clock, reset_n           : clock, asynchronous active-low reset
//   dBus_cmd_valid/ready     : command handshake
//   dBus_cmd_payload_wr      : 1 write, 0 read
//   dBus_cmd_payload_address : byte address
//   dBus_cmd_payload_data    : lane-replicated write data
//   dBus_cmd_payload_size    : 0 byte, 1 half, 2 word, 3 illegal
//   dBus_rsp_ready           : read response strobe
//   dBus_rsp_data            : aligned word of the response
//   dBus_rsp_error           : error flag, qualified by dBus_rsp_ready
// Build option: define DBUS_RESP_STALL_EN to add LFSR-driven command/response stalls.
module dbus_mem_responder
    import dbus_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned RSP_LATENCY = 2,
    parameter int unsigned MAX_PENDING = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dBus_cmd_valid,
    output logic        dBus_cmd_ready,
    input  logic        dBus_cmd_payload_wr,
    input  logic [31:0] dBus_cmd_payload_address,
    input  logic [31:0] dBus_cmd_payload_data,
    input  logic [1:0]  dBus_cmd_payload_size,
    output logic        dBus_rsp_ready,
    output logic [31:0] dBus_rsp_data,
    output logic        dBus_rsp_error
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OUT_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

    logic [31:0]      ram [MEM_WORDS];
    logic             live;
    logic [OUT_W-1:0] outstanding;
    logic             cmd_stall;
    logic             rsp_stall;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             cmd_err;
    logic             accept;
    logic             rd_acc;
    logic             wr_acc;
    logic [3:0]       wr_mask;
    rsp_entry_t       stage0_entry;

    rsp_entry_t             pipe_entry [RSP_LATENCY];
    logic [RSP_LATENCY-1:0] pipe_valid;

    rsp_entry_t       fifo_head;
    logic             fifo_empty;
    logic             pop;
    logic [CNT_W-1:0] unused_fifo_count;

    assign word_idx = dBus_cmd_payload_address[IDX_W+1:2];
    assign lane     = dBus_cmd_payload_address[1:0];
    assign cmd_err  = (dBus_cmd_payload_address[31:IDX_W+2] != '0)
                   || (size_e'(dBus_cmd_payload_size) == SZ_ILLEGAL)
                   || is_misaligned(dBus_cmd_payload_size, lane);
    assign wr_mask  = byte_mask(dBus_cmd_payload_size, lane);

    // live keeps cmd_ready low while reset is held, since the counter alone would read as idle
    assign dBus_cmd_ready = live && (outstanding < OUT_W'(MAX_PENDING)) && !cmd_stall;
    assign accept = dBus_cmd_valid && dBus_cmd_ready;
    assign rd_acc = accept && !dBus_cmd_payload_wr;
    assign wr_acc = accept && dBus_cmd_payload_wr && !cmd_err;

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_mask[i]) ram[word_idx][8*i +: 8] <= dBus_cmd_payload_data[8*i +: 8];
            end
        end
    end

    // Read data is captured at the accept edge, before any later write can touch it
    always_comb begin
        stage0_entry.error = cmd_err;
        stage0_entry.data  = cmd_err ? '0 : ram[word_idx];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_acc;
            for (int unsigned i = 1; i < RSP_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
    end

    always_ff @(posedge clock) begin
        pipe_entry[0] <= stage0_entry;
        for (int unsigned i = 1; i < RSP_LATENCY; i++) pipe_entry[i] <= pipe_entry[i-1];
    end

    // Occupancy never exceeds outstanding, so MAX_PENDING entries cannot overflow
    dbus_rsp_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_rsp_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (pipe_valid[RSP_LATENCY-1]),
        .push_entry (pipe_entry[RSP_LATENCY-1]),
        .pop        (pop),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .count      (unused_fifo_count)
    );

    assign pop = !fifo_empty && !rsp_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live           <= 1'b0;
            outstanding    <= '0;
            dBus_rsp_ready <= 1'b0;
            dBus_rsp_data  <= '0;
            dBus_rsp_error <= 1'b0;
        end else begin
            live           <= 1'b1;
            dBus_rsp_ready <= pop;
            dBus_rsp_data  <= pop ? fifo_head.data : '0;
            dBus_rsp_error <= pop && fifo_head.error;
            case ({rd_acc, pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef DBUS_RESP_STALL_EN
    logic [15:0] lfsr;
    logic [1:0]  cmd_run;
    logic [1:0]  rsp_run;

    // A run counter at 3 masks the LFSR bit for one cycle so neither side starves
    assign cmd_stall = lfsr[0] && (cmd_run != 2'd3);
    assign rsp_stall = lfsr[1] && (rsp_run != 2'd3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr    <= LFSR_SEED;
            cmd_run <= '0;
            rsp_run <= '0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cmd_run <= cmd_stall ? cmd_run + 2'd1 : '0;
            rsp_run <= rsp_stall ? rsp_run + 2'd1 : '0;
        end
    end
`else
    logic [15:0] unused_lfsr_seed;

    assign unused_lfsr_seed = LFSR_SEED;
    assign cmd_stall = 1'b0;
    assign rsp_stall = 1'b0;
`endif

endmodule
